// File: rtl/aes_round_ctrl.sv
// AES round controller: sequences one block through AddRoundKey, NR-1 full
// rounds and a final round without MixColumns. SubBytes, ShiftRows and
// MixColumns are external combinational logic driven from dp_state.
`timescale 1ns/1ps

module aes_round_ctrl #(
    parameter int NR = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_block,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic         rk_valid,
    input  logic [255:0] rk_data,
    output logic [255:0] dp_state,
    input  logic [255:0] dp_shift_res,
    input  logic [255:0] dp_mix_res,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_block,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [3:0] LAST_RND = 4'(NR);

    fsm_t         cur, nxt;
    logic [255:0] state_q;
    logic [3:0]   rnd;

    // FSM state register with synchronous reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) cur <= IDLE;
        else        cur <= nxt;
    end

    // Next-state decode.
    // NOTE: nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    if (in_valid) nxt = RUN;
            RUN:     if (rk_valid && rnd == LAST_RND) nxt = DONE;
            DONE:    if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Block state and round counter: load on accept, one round per key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '0;
            rnd     <= '0;
        end else begin
            case (cur)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_block;
                        rnd     <= '0;
                    end
                end
                RUN: begin
                    if (rk_valid) begin
                        if (rnd == 4'd0)
                            state_q <= state_q ^ rk_data;           // initial AddRoundKey
                        else if (rnd == LAST_RND)
                            state_q <= dp_shift_res ^ rk_data;      // final round, no MixColumns
                        else
                            state_q <= dp_mix_res ^ rk_data;        // full round
                        if (rnd < LAST_RND)
                            rnd <= rnd + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the FSM state.
    always_comb begin
        in_ready  = 1'b0;
        rk_req    = 1'b0;
        rk_idx    = 4'd0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (cur)
            IDLE: in_ready = 1'b1;
            RUN: begin
                rk_req = 1'b1;
                rk_idx = rnd;
                busy   = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign dp_state  = state_q;
    assign out_block = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: NR=14 instance with selectable datapath
// and key stubs plus an NR=1 instance; a scoreboard queue tracks ciphertexts.
`timescale 1ns/1ps

module tb_aes_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, rk_valid, out_ready;
    logic [255:0] in_block, rk_data, dp_shift_res, dp_mix_res;
    logic         in_ready, rk_req, out_valid, busy;
    logic [3:0]   rk_idx;
    logic [255:0] dp_state, out_block;

    logic         in_valid_b, rk_valid_b, out_ready_b;
    logic [255:0] in_block_b, rk_data_b, dp_shift_res_b, dp_mix_res_b;
    logic         in_ready_b, rk_req_b, out_valid_b, busy_b;
    logic [3:0]   rk_idx_b;
    logic [255:0] dp_state_b, out_block_b;

    int dp_mode  = 0;   // 0: identity stubs, 1: byte-rotate / xor-rotate stubs
    int key_mode = 0;   // 0: zero-extended index, 1: zero, 2: hashed index
    int errors   = 0;
    int checks   = 0;
    logic [255:0] sb_q[$];

    aes_round_ctrl #(.NR(14)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .rk_req(rk_req), .rk_idx(rk_idx), .rk_valid(rk_valid),
        .rk_data(rk_data), .dp_state(dp_state), .dp_shift_res(dp_shift_res),
        .dp_mix_res(dp_mix_res), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .busy(busy)
    );

    aes_round_ctrl #(.NR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_block(in_block_b), .rk_req(rk_req_b), .rk_idx(rk_idx_b), .rk_valid(rk_valid_b),
        .rk_data(rk_data_b), .dp_state(dp_state_b), .dp_shift_res(dp_shift_res_b),
        .dp_mix_res(dp_mix_res_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_block(out_block_b), .busy(busy_b)
    );

    function automatic logic [255:0] shift_fn(input int m, input logic [255:0] s);
        if (m == 0) return s;
        return {s[247:0], s[255:248]};
    endfunction

    function automatic logic [255:0] mix_fn(input int m, input logic [255:0] s);
        if (m == 0) return s;
        return s ^ {s[254:0], s[255]};
    endfunction

    function automatic logic [255:0] key_fn(input int m, input logic [3:0] idx);
        logic [31:0] w;
        w = {28'h0, idx} * 32'h9E3779B9 + 32'h01234567;
        case (m)
            0:       return {248'h0, 4'h0, idx};
            1:       return '0;
            default: return {w, ~w, w ^ 32'hA5A5A5A5, w, ~w, w, w ^ 32'h5A5A5A5A, w};
        endcase
    endfunction

    function automatic logic [255:0] model(input logic [255:0] blk, input int nr,
                                           input int dm, input int km);
        logic [255:0] s;
        s = blk ^ key_fn(km, 4'd0);
        for (int r = 1; r < nr; r++)
            s = mix_fn(dm, shift_fn(dm, s)) ^ key_fn(km, 4'(r));
        s = shift_fn(dm, s) ^ key_fn(km, 4'(nr));
        return s;
    endfunction

    always_comb begin
        dp_shift_res   = shift_fn(dp_mode, dp_state);
        dp_mix_res     = mix_fn(dp_mode, dp_shift_res);
        rk_data        = key_fn(key_mode, rk_idx);
        dp_shift_res_b = shift_fn(1, dp_state_b);
        dp_mix_res_b   = mix_fn(1, dp_shift_res_b);
        rk_data_b      = key_fn(2, rk_idx_b);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push the model result on an accept, pop on an output handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (in_valid && in_ready)
                sb_q.push_back(model(in_block, 14, dp_mode, key_mode));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_unexpected_output observed=%h expected=none", out_block);
                end else begin
                    check("sb_out_block", out_block, sb_q.pop_front());
                end
            end
        end
    end

    // Accept one block, feed keys (optionally stalling at one round), wait for DONE.
    task automatic do_block(input logic [255:0] blk, input int stall_rnd,
                            input int stall_len, input int exp_lat, input string tag);
        int lat, stalled;
        in_block = blk;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"},     256'(busy), 256'(1));
        check({tag, "_in_ready"}, 256'(in_ready), 256'(0));
        check({tag, "_rk0"},      256'({rk_req, rk_idx}), 256'({1'b1, 4'd0}));
        lat = 0;
        stalled = 0;
        while (!out_valid && lat < 60) begin
            if (rk_req && int'(rk_idx) == stall_rnd && stalled < stall_len) begin
                rk_valid = 1'b0;
                stalled++;
            end else begin
                rk_valid = 1'b1;
            end
            tick();
            lat++;
            if (!rk_valid) check({tag, "_stall_idx"}, 256'(rk_idx), 256'(stall_rnd));
        end
        rk_valid = 1'b1;
        check({tag, "_latency"}, 256'(lat), 256'(exp_lat));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, 256'({in_ready, busy, out_valid}), 256'({1'b1, 1'b0, 1'b0}));
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        logic [255:0] r;
        int n;
        bit seen;

        rst_n = 1'b0; in_valid = 1'b0; rk_valid = 1'b1; out_ready = 1'b0; in_block = '0;
        in_valid_b = 1'b0; rk_valid_b = 1'b1; out_ready_b = 1'b0; in_block_b = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready",  256'(in_ready), 256'(1));
        check("rst_busy",      256'(busy), 256'(0));
        check("rst_rk_req",    256'(rk_req), 256'(0));
        check("rst_rk_idx",    256'(rk_idx), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_dp_state",  dp_state, 256'h0);

        // Identity stubs, index keys: xor of 0..14 is 0x0F
        do_block(256'h0, -1, 0, 15, "t1");
        check("t1_out", out_block, 256'h0F);
        release_out("t1");

        // Three-cycle key stall at round 5
        do_block(256'h0, 5, 3, 18, "t2");
        check("t2_out", out_block, 256'h0F);
        release_out("t2");

        // All-FF block, zero keys, consumer back-pressure with in_valid offered
        key_mode = 1;
        do_block({32{8'hFF}}, -1, 0, 15, "t3");
        in_valid = 1'b1;
        in_block = 256'h1234;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold", 256'({out_valid, in_ready}), 256'({1'b1, 1'b0}));
            check("t3_hold_blk", out_block, {32{8'hFF}});
        end
        in_valid = 1'b0;
        release_out("t3");

        // Non-trivial datapath and keys, with and without stall
        dp_mode = 1;
        key_mode = 2;
        do_block(rand256(), -1, 0, 15, "t4");
        release_out("t4");
        do_block(rand256(), 9, 2, 17, "t4s");
        release_out("t4s");

        // Back-to-back offers: next accept one cycle after DONE->IDLE
        in_block = rand256();
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check("t5_no_accept_on_exit", 256'({in_ready, busy}), 256'({1'b1, 1'b0}));
        tick();
        n++;
        check("t5_accept_gap", 256'(n), 256'(17));
        check("t5_restart", 256'({busy, rk_idx}), 256'({1'b1, 4'd0}));
        in_valid = 1'b0;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check("t5_second_done", 256'(n), 256'(16));
        out_ready = 1'b0;

        // Reset at round 7 aborts the block
        dp_mode = 0;
        key_mode = 0;
        in_block = rand256();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (rk_idx != 4'd7 && n < 30) begin
            tick();
            n++;
        end
        check("t6_at_rnd7", 256'(rk_idx), 256'(7));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb_q.delete();
        check("t6_flags", 256'({in_ready, rk_req, busy, out_valid, rk_idx}),
              256'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0}));
        check("t6_state", dp_state, 256'h0);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        check("t6_no_out_pulse", 256'(seen), 256'(0));

        // First edge after reset release accepts
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        do_block(rand256(), -1, 0, 15, "t7");
        release_out("t7");

        // NR=1 instance
        r = rand256();
        in_block_b = r;
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        check("b_idx0", 256'({rk_req_b, rk_idx_b}), 256'({1'b1, 4'd0}));
        tick();
        check("b_idx1", 256'({rk_req_b, rk_idx_b, out_valid_b}), 256'({1'b1, 4'd1, 1'b0}));
        tick();
        check("b_out_valid", 256'(out_valid_b), 256'(1));
        check("b_out_block", out_block_b,
              shift_fn(1, r ^ key_fn(2, 4'd0)) ^ key_fn(2, 4'd1));
        out_ready_b = 1'b1;
        tick();
        out_ready_b = 1'b0;
        check("b_idle", 256'({in_ready_b, out_valid_b}), 256'({1'b1, 1'b0}));

        check("sb_drained", 256'(sb_q.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 14, meaning number of cipher rounds for the 256-bit Rijndael block; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  plaintext block offered.
REQ-005 in_ready  output  1  controller can accept a block.
REQ-006 in_block  input  256  plaintext, words w0..w7, w0 = bits [255:224].
REQ-007 rk_req  output  1  round key requested.
REQ-008 rk_idx  output  4  index of requested round key, 0..NR.
REQ-009 rk_valid  input  1  rk_data holds key rk_idx this cycle.
REQ-010 rk_data  input  256  round key.
REQ-011 dp_state  output  256  current state register, driven to external SubBytes->ShiftRows->MixColumns chain.
REQ-012 dp_shift_res  input  256  ShiftRows(SubBytes(dp_state)), combinational, same cycle.
REQ-013 dp_mix_res  input  256  MixColumns(dp_shift_res), combinational, same cycle.
REQ-014 out_valid  output  1  ciphertext available.
REQ-015 out_ready  input  1  consumer accepts ciphertext.
REQ-016 out_block  output  256  ciphertext, equals dp_state while out_valid.
REQ-017 busy  output  1  high in RUN and DONE.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE; the block holds one 256-bit state register and a 4-bit round counter rnd.
REQ-019 IDLE: in_ready=1; on an edge with in_valid=1, state<=in_block, rnd<=0, go RUN; in_block otherwise ignored.
REQ-020 in_ready SHALL be 0 in RUN and DONE; no input is accepted until return to IDLE.
REQ-021 RUN: rk_req=1, rk_idx=rnd, held stable until an edge with rk_valid=1; an edge with rk_valid=0 leaves state and rnd unchanged.
REQ-022 RUN edge with rk_valid=1 and rnd=0: state<=state XOR rk_data.
REQ-023 RUN edge with rk_valid=1 and 1<=rnd<=NR-1: state<=dp_mix_res XOR rk_data.
REQ-024 RUN edge with rk_valid=1 and rnd=NR: state<=dp_shift_res XOR rk_data (no MixColumns), go DONE.
REQ-025 Every RUN edge with rk_valid=1 and rnd<NR SHALL increment rnd by 1; rnd never exceeds NR.
REQ-026 rk_req SHALL be 0 outside RUN; rk_valid outside RUN is ignored.
REQ-027 DONE: out_valid=1, out_block=state, both stable until an edge with out_ready=1, then go IDLE.
REQ-028 out_valid=1 with out_ready=0 SHALL hold indefinitely with no change to out_block.
REQ-029 Minimum latency, rk_valid tied high: out_valid rises NR+1 cycles after the accept edge (15 for NR=14); back-to-back throughput is one block per NR+3 cycles.
REQ-030 The DONE->IDLE edge SHALL NOT accept a new block; acceptance requires a cycle in IDLE.
REQ-031 dp_state SHALL always equal the state register, in every FSM state.

Reset
REQ-032 An edge with rst_n=0 SHALL force IDLE, rnd=0, state=0, out_valid=0, rk_req=0, rk_idx=0, busy=0, in_ready=1 on the following cycle, regardless of FSM state or other inputs.
REQ-033 Reset mid-RUN or mid-DONE SHALL discard the block; no out_valid pulse follows.
REQ-034 The first edge after rst_n returns to 1 SHALL accept a block when in_valid=1.

Verification
REQ-035 Identity datapath stubs (dp_shift_res=dp_state, dp_mix_res=dp_shift_res), in_block=0, rk_data={248'h0, rk_idx zero-extended to 8 bits}, rk_valid=1 -> out_block=256'h0F, out_valid 15 cycles after accept.
REQ-036 Same as REQ-035 with rk_valid=0 for 3 cycles at rnd=5 -> rk_idx stays 5 during stall, out_valid 18 cycles after accept, out_block=256'h0F.
REQ-037 Identity stubs, in_block=all 0xFF bytes, rk_data=0 -> out_block=all 0xFF; out_ready held 0 for 10 cycles -> out_valid and out_block stable, in_ready=0 throughout.
REQ-038 Two blocks offered back-to-back with in_valid held 1 -> second accepted exactly one cycle after DONE->IDLE; rk_idx restarts at 0.
REQ-039 rst_n=0 for one edge at rnd=7 -> next cycle IDLE, state=0, rk_req=0, in_ready=1; no out_valid pulse for the aborted block.
REQ-040 NR=1 build: rk_idx sequence 0,1 -> out_block=dp_shift_res(in_block XOR rk0) XOR rk1, out_valid 2 cycles after accept.
